// File: rtl/pipe_pkg.sv
// Shared encodings and defaults for the MIPS pipeline hazard controller.
package pipe_pkg;

    localparam logic [1:0]  TUSE_NONE    = 2'd3;
    localparam logic [31:0] EXC_VECTOR   = 32'h0000_4180;
    localparam int          MULT_CYC_DEF = 5;
    localparam int          DIV_CYC_DEF  = 10;

    typedef enum logic [1:0] {
        PC_SEL_NORMAL = 2'd0,
        PC_SEL_EXC    = 2'd1,
        PC_SEL_EPC    = 2'd2
    } pc_sel_e;

    // An operand must wait if a younger-needed value is still being produced in E or M.
    function automatic logic operand_stall(
        input logic [4:0] addr,
        input logic [1:0] tuse,
        input logic [4:0] e_wa,
        input logic [1:0] e_tnew,
        input logic [4:0] m_wa,
        input logic [1:0] m_tnew
    );
        return (addr != 5'd0) && (tuse != TUSE_NONE) &&
               (((addr == e_wa) && (tuse < e_tnew)) ||
                ((addr == m_wa) && (tuse < m_tnew)));
    endfunction

endpackage

// File: rtl/md_busy_timer.sv
// Busy counter for the multicycle mult/div unit; busy and done are registered.
module md_busy_timer
    import pipe_pkg::*;
#(
    parameter int MULT_CYC = MULT_CYC_DEF,
    parameter int DIV_CYC  = DIV_CYC_DEF,
    parameter int CNT_W    = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic is_div,
    input  logic kill,
    output logic busy,
    output logic done
);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             busy_q, done_q;

    // Next count: a killed start is dropped, a running operation always drains.
    always_comb begin
        cnt_d = cnt_q;
        if (start && !kill) begin
            cnt_d = is_div ? CNT_W'(DIV_CYC) : CNT_W'(MULT_CYC);
        end else if (cnt_q != {CNT_W{1'b0}}) begin
            cnt_d = cnt_q - {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Counter and flags, decoded from the next count so they line up with cnt_q.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q  <= {CNT_W{1'b0}};
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            busy_q <= (cnt_d != {CNT_W{1'b0}});
            done_q <= (cnt_d == {{(CNT_W-1){1'b0}}, 1'b1});
        end
    end

    assign busy = busy_q;
    assign done = done_q;

    md_busy_timer_chk u_chk (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .busy  (busy_q)
    );

endmodule

// File: rtl/md_busy_timer_chk.sv
// Property checks for the mult/div busy timer.
module md_busy_timer_chk (
    input logic clk,
    input logic reset,
    input logic start,
    input logic busy
);

    // A new mult/div may only enter E once the previous one has drained.
    start_when_idle_a: assert property (@(posedge clk) disable iff (reset) start |-> !busy)
        else $error("md_busy_timer: start issued while unit busy");

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush controller for the 5-stage pipeline: data and mult/div hazards,
// exception and eret redirects, and the pipeline-register enables/clears.
module pipe_hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int MULT_CYC = MULT_CYC_DEF,
    parameter int DIV_CYC  = DIV_CYC_DEF,
    parameter int CNT_W    = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] D_rs_addr,
    input  logic [4:0] D_rt_addr,
    input  logic [1:0] D_rs_tuse,
    input  logic [1:0] D_rt_tuse,
    input  logic [4:0] E_wa,
    input  logic [1:0] E_tnew,
    input  logic [4:0] M_wa,
    input  logic [1:0] M_tnew,
    input  logic       D_md_instr,
    input  logic       E_md_start,
    input  logic       E_md_is_div,
    input  logic       D_eret,
    input  logic       Req,
    output logic       pc_en,
    output logic [1:0] pc_sel,
    output logic       fd_en,
    output logic       fd_clear,
    output logic       de_clear,
    output logic       em_clear,
    output logic       mw_clear,
    output logic       md_busy,
    output logic       md_done,
    output logic       stall
);

    logic rs_stall_s, rt_stall_s, data_stall_s, md_stall_s, stall_s;

    md_busy_timer #(
        .MULT_CYC (MULT_CYC),
        .DIV_CYC  (DIV_CYC),
        .CNT_W    (CNT_W)
    ) u_md_timer (
        .clk    (clk),
        .reset  (reset),
        .start  (E_md_start),
        .is_div (E_md_is_div),
        .kill   (Req),
        .busy   (md_busy),
        .done   (md_done)
    );

    assign rs_stall_s   = operand_stall(D_rs_addr, D_rs_tuse, E_wa, E_tnew, M_wa, M_tnew);
    assign rt_stall_s   = operand_stall(D_rt_addr, D_rt_tuse, E_wa, E_tnew, M_wa, M_tnew);
    assign data_stall_s = rs_stall_s | rt_stall_s;
    assign md_stall_s   = D_md_instr & (md_busy | E_md_start);
    assign stall_s      = (data_stall_s | md_stall_s) & ~Req;

    // Fixed-priority control mux; reset holds every stage flushed and frozen.
    always_comb begin
        pc_en    = 1'b0;
        pc_sel   = PC_SEL_NORMAL;
        fd_en    = 1'b0;
        fd_clear = 1'b1;
        de_clear = 1'b1;
        em_clear = 1'b1;
        mw_clear = 1'b1;
        stall    = 1'b0;
        if (reset) begin
            pc_en = 1'b0;
        end else if (Req) begin
            // The faulting instruction sits in M and is cancelled by CP0, so M/W is untouched.
            pc_en    = 1'b1;
            pc_sel   = PC_SEL_EXC;
            fd_en    = 1'b1;
            mw_clear = 1'b0;
        end else if (stall_s) begin
            stall    = 1'b1;
            fd_clear = 1'b0;
            em_clear = 1'b0;
            mw_clear = 1'b0;
        end else if (D_eret) begin
            pc_en    = 1'b1;
            pc_sel   = PC_SEL_EPC;
            fd_en    = 1'b1;
            de_clear = 1'b0;
            em_clear = 1'b0;
            mw_clear = 1'b0;
        end else begin
            pc_en    = 1'b1;
            fd_en    = 1'b1;
            fd_clear = 1'b0;
            de_clear = 1'b0;
            em_clear = 1'b0;
            mw_clear = 1'b0;
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: directed hazard scenarios then randomized traffic.
module tb_pipe_hazard_ctrl;

    localparam int MULT_N = 5;
    localparam int DIV_N  = 10;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [4:0] D_rs_addr = 5'd0, D_rt_addr = 5'd0, E_wa = 5'd0, M_wa = 5'd0;
    logic [1:0] D_rs_tuse = 2'd3, D_rt_tuse = 2'd3, E_tnew = 2'd0, M_tnew = 2'd0;
    logic       D_md_instr = 1'b0, E_md_start = 1'b0, E_md_is_div = 1'b0;
    logic       D_eret = 1'b0, Req = 1'b0;
    logic       pc_en, fd_en, fd_clear, de_clear, em_clear, mw_clear;
    logic       md_busy, md_done, stall;
    logic [1:0] pc_sel;

    typedef struct packed {
        logic [4:0] rs_addr;
        logic [4:0] rt_addr;
        logic [1:0] rs_tuse;
        logic [1:0] rt_tuse;
        logic [4:0] e_wa;
        logic [1:0] e_tnew;
        logic [4:0] m_wa;
        logic [1:0] m_tnew;
        logic       md_instr;
        logic       md_start;
        logic       md_is_div;
        logic       eret;
        logic       req;
    } stim_t;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int mon_cyc = 0;
    logic [11:0] exp_q[$];

    // Reference: the single outstanding mult/div as (start cycle, length).
    bit op_live = 1'b0;
    int op_t = 0;
    int op_n = 0;

    pipe_hazard_ctrl dut (
        .clk         (clk),
        .reset       (reset),
        .D_rs_addr   (D_rs_addr),
        .D_rt_addr   (D_rt_addr),
        .D_rs_tuse   (D_rs_tuse),
        .D_rt_tuse   (D_rt_tuse),
        .E_wa        (E_wa),
        .E_tnew      (E_tnew),
        .M_wa        (M_wa),
        .M_tnew      (M_tnew),
        .D_md_instr  (D_md_instr),
        .E_md_start  (E_md_start),
        .E_md_is_div (E_md_is_div),
        .D_eret      (D_eret),
        .Req         (Req),
        .pc_en       (pc_en),
        .pc_sel      (pc_sel),
        .fd_en       (fd_en),
        .fd_clear    (fd_clear),
        .de_clear    (de_clear),
        .em_clear    (em_clear),
        .mw_clear    (mw_clear),
        .md_busy     (md_busy),
        .md_done     (md_done),
        .stall       (stall)
    );

    always #5 clk = ~clk;

    function automatic bit model_busy(input int c);
        return op_live && (c > op_t) && (c <= op_t + op_n);
    endfunction

    function automatic bit waits_on(input int addr, input int tuse, input int wa, input int tnew);
        return (addr != 0) && (tuse != 3) && (addr == wa) && (tuse < tnew);
    endfunction

    function automatic logic [11:0] predict(input stim_t s, input bit rst, input int c);
        bit busy, done, dstall, st;
        logic pe, fe, fc, dc, ec, mc;
        logic [1:0] ps;
        busy = !rst && model_busy(c);
        done = !rst && op_live && (c == op_t + op_n);
        dstall = waits_on(s.rs_addr, s.rs_tuse, s.e_wa, s.e_tnew) ||
                 waits_on(s.rs_addr, s.rs_tuse, s.m_wa, s.m_tnew) ||
                 waits_on(s.rt_addr, s.rt_tuse, s.e_wa, s.e_tnew) ||
                 waits_on(s.rt_addr, s.rt_tuse, s.m_wa, s.m_tnew);
        st = (dstall || (s.md_instr && (busy || s.md_start))) && !s.req && !rst;
        if (rst)         {pe, ps, fe, fc, dc, ec, mc} = {1'b0, 2'd0, 1'b0, 4'b1111};
        else if (s.req)  {pe, ps, fe, fc, dc, ec, mc} = {1'b1, 2'd1, 1'b1, 4'b1110};
        else if (st)     {pe, ps, fe, fc, dc, ec, mc} = {1'b0, 2'd0, 1'b0, 4'b0100};
        else if (s.eret) {pe, ps, fe, fc, dc, ec, mc} = {1'b1, 2'd2, 1'b1, 4'b1000};
        else             {pe, ps, fe, fc, dc, ec, mc} = {1'b1, 2'd0, 1'b1, 4'b0000};
        return {pe, ps, fe, fc, dc, ec, mc, busy, done, st};
    endfunction

    task automatic drive(input stim_t s, input bit rst_now, input bit rst_mid);
        @(posedge clk);
        #1;
        D_rs_addr   = s.rs_addr;
        D_rt_addr   = s.rt_addr;
        D_rs_tuse   = s.rs_tuse;
        D_rt_tuse   = s.rt_tuse;
        E_wa        = s.e_wa;
        E_tnew      = s.e_tnew;
        M_wa        = s.m_wa;
        M_tnew      = s.m_tnew;
        D_md_instr  = s.md_instr;
        E_md_start  = s.md_start;
        E_md_is_div = s.md_is_div;
        D_eret      = s.eret;
        Req         = s.req;
        reset       = rst_now;
        if (rst_mid) begin
            #2;
            reset = 1'b1;
        end
        exp_q.push_back(predict(s, reset, cyc));
        if (reset) begin
            op_live = 1'b0;
        end else if (s.md_start && !s.req) begin
            op_live = 1'b1;
            op_t    = cyc;
            op_n    = s.md_is_div ? DIV_N : MULT_N;
        end
        cyc++;
    endtask

    function automatic stim_t rand_stim(input bit allow_start);
        stim_t s;
        s.rs_addr   = 5'($urandom_range(0, 3));
        s.rt_addr   = 5'($urandom_range(0, 3));
        s.rs_tuse   = 2'($urandom_range(0, 3));
        s.rt_tuse   = 2'($urandom_range(0, 3));
        s.e_wa      = 5'($urandom_range(0, 3));
        s.e_tnew    = 2'($urandom_range(0, 2));
        s.m_wa      = 5'($urandom_range(0, 3));
        s.m_tnew    = 2'($urandom_range(0, 2));
        s.md_instr  = ($urandom_range(0, 3) == 0);
        s.md_start  = allow_start && ($urandom_range(0, 5) == 0);
        s.md_is_div = 1'($urandom_range(0, 1));
        s.eret      = ($urandom_range(0, 7) == 0);
        s.req       = ($urandom_range(0, 9) == 0);
        return s;
    endfunction

    // Monitor: one expected response per cycle, compared mid-cycle.
    always @(negedge clk) begin
        logic [11:0] e_v, a_v;
        if (exp_q.size() != 0) begin
            e_v = exp_q.pop_front();
            a_v = {pc_en, pc_sel, fd_en, fd_clear, de_clear, em_clear, mw_clear, md_busy, md_done, stall};
            total++;
            if (a_v !== e_v) begin
                bad++;
                $display("FAIL ctrl_outputs cyc=%0d actual=%b required=%b (pc_en,pc_sel,fd_en,fd/de/em/mw_clear,busy,done,stall)",
                         mon_cyc, a_v, e_v);
            end
            mon_cyc++;
        end
    end

    initial begin
        stim_t s, z;
        z = '0;
        z.rs_tuse = 2'd3;
        z.rt_tuse = 2'd3;

        drive(z, 1'b1, 1'b0);
        drive(z, 1'b1, 1'b0);

        // Load-use then resolved one stage later.
        s = z; s.e_wa = 5'd1; s.e_tnew = 2'd2; s.rs_addr = 5'd1; s.rs_tuse = 2'd1;
        drive(s, 1'b0, 1'b0);
        s = z; s.m_wa = 5'd1; s.m_tnew = 2'd1; s.rs_addr = 5'd1; s.rs_tuse = 2'd1;
        drive(s, 1'b0, 1'b0);

        // $0 destination and an unread operand never stall.
        s = z; s.e_wa = 5'd0; s.e_tnew = 2'd2; s.rs_addr = 5'd0; s.rs_tuse = 2'd0;
        drive(s, 1'b0, 1'b0);
        s = z; s.e_wa = 5'd5; s.e_tnew = 2'd2; s.rt_addr = 5'd5; s.rt_tuse = 2'd3;
        drive(s, 1'b0, 1'b0);

        // Div then mult, with mflo held in D for the whole busy window.
        for (int k = 0; k < 2; k++) begin
            s = z; s.md_start = 1'b1; s.md_is_div = (k == 0); s.md_instr = 1'b1;
            drive(s, 1'b0, 1'b0);
            s = z; s.md_instr = 1'b1;
            for (int i = 0; i < ((k == 0) ? DIV_N : MULT_N) + 1; i++) drive(s, 1'b0, 1'b0);
        end

        // Exception during a data stall while a mult is running.
        s = z; s.md_start = 1'b1;
        drive(s, 1'b0, 1'b0);
        s = z; s.e_wa = 5'd2; s.e_tnew = 2'd2; s.rt_addr = 5'd2; s.rt_tuse = 2'd0; s.req = 1'b1;
        drive(s, 1'b0, 1'b0);
        for (int i = 0; i < MULT_N; i++) drive(z, 1'b0, 1'b0);

        // A start that coincides with an exception is dropped.
        s = z; s.md_start = 1'b1; s.md_is_div = 1'b1; s.req = 1'b1;
        drive(s, 1'b0, 1'b0);
        drive(z, 1'b0, 1'b0);

        // Async reset between edges with the div counter at 6, then eret.
        s = z; s.md_start = 1'b1; s.md_is_div = 1'b1;
        drive(s, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) drive(z, 1'b0, 1'b0);
        drive(z, 1'b0, 1'b1);
        s = z; s.eret = 1'b1;
        drive(s, 1'b0, 1'b0);
        drive(z, 1'b0, 1'b0);

        for (int i = 0; i < 800; i++) begin
            bit rst_now, rst_mid;
            rst_now = ($urandom_range(0, 99) == 0);
            rst_mid = !rst_now && ($urandom_range(0, 99) == 0);
            s = rand_stim(!model_busy(cyc));
            drive(s, rst_now, rst_mid);
        end

        @(negedge clk);
        #1;
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain actual=%0d required=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
